// File: rtl/vga_line_prefetch_if.sv
// FML read-master bus plus the byte-stream pixel port of the line prefetcher.
// The master modport is the prefetcher side. The slave modport is the memory/pixel side.
interface vga_line_prefetch_if #(
  parameter int unsigned fml_depth = 25
);
  logic [fml_depth-1:0] fml_adr;
  logic                 fml_stb;
  logic                 fml_ack;
  logic [15:0]          fml_di;
  logic                 pix_rd;
  logic [7:0]           pix_data;
  logic                 pix_valid;

  modport master (
    output fml_adr, fml_stb, pix_data, pix_valid,
    input  fml_ack, fml_di, pix_rd
  );

  modport slave (
    input  fml_adr, fml_stb, pix_data, pix_valid,
    output fml_ack, fml_di, pix_rd
  );
endinterface

// File: rtl/vga_line_prefetch.sv
// Per-scanline FML burst reader feeding a word FIFO.
// The FIFO is presented to the pixel stage as a low-byte-first show-ahead byte stream.
module vga_line_prefetch #(
  parameter int unsigned          fml_depth      = 25,
  parameter logic [fml_depth-1:0] FB_BASE        = 'h0A0000,
  parameter int unsigned          WORDS_PER_LINE = 160,
  parameter int unsigned          FIFO_AW        = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [15:0]         start_addr,
  input  logic                frame_start,
  input  logic                line_start,
  input  logic                line_repeat,
  vga_line_prefetch_if.master bus,
  output logic                busy,
  output logic                underrun
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int unsigned WCW   = $clog2(WORDS_PER_LINE + 1);
  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam logic [WCW-1:0] WPL        = WCW'(WORDS_PER_LINE);
  localparam logic [15:0]    LINE_BYTES = 16'(2 * WORDS_PER_LINE);

  logic [1:0]         state, state_nx;
  logic               stb, stb_nx;
  logic [15:0]        adr_off, adr_nx;
  logic [WCW-1:0]     wcnt, wcnt_nx;
  logic [15:0]        line_base, next_base;
  logic [15:0]        base_fs, base_now, base_sel;

  logic [15:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [CW-1:0]      count, count_nx;
  logic               phase;
  logic [7:0]         last_byte, pix_data_w;
  logic               pix_valid_w;

  logic pending, word_ack, push, pop_byte, pop_word;

  assign base_fs  = 16'(start_addr << 1);
  assign base_now = frame_start ? base_fs : next_base;
  assign base_sel = line_repeat ? line_base : base_now;

  assign word_ack    = bus.fml_ack & stb;
  assign pending     = stb & ~bus.fml_ack;
  assign pix_valid_w = (count != '0);
  assign pop_byte    = bus.pix_rd & pix_valid_w;
  assign pop_word    = pop_byte & phase;
  assign push        = word_ack & (state == FETCH) & ~line_start;

  always_comb begin
    count_nx = count;
    if (line_start)
      count_nx = '0;
    else if (push && !pop_word)
      count_nx = count + 1'b1;
    else if (!push && pop_word)
      count_nx = count - 1'b1;
  end

  // A request already on the bus is never withdrawn; a line_start that hits one parks in DRAIN.
  always_comb begin
    state_nx = state;
    adr_nx   = adr_off;
    wcnt_nx  = wcnt;
    case (state)
      IDLE: begin
        if (line_start) begin
          state_nx = FETCH;
          adr_nx   = base_sel;
          wcnt_nx  = '0;
        end
      end
      FETCH: begin
        if (line_start && pending) begin
          state_nx = DRAIN;
        end else if (line_start) begin
          adr_nx  = base_sel;
          wcnt_nx = '0;
        end else if (word_ack) begin
          adr_nx  = adr_off + 16'd2;
          wcnt_nx = wcnt + 1'b1;
          if (wcnt == WPL - 1'b1)
            state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (word_ack) begin
          state_nx = FETCH;
          adr_nx   = line_start ? base_sel : line_base;
          wcnt_nx  = '0;
        end
      end
      default: state_nx = IDLE;
    endcase

    stb_nx = 1'b0;
    if ((state == FETCH || state == DRAIN) && pending)
      stb_nx = 1'b1;
    else if (state_nx == FETCH && count_nx < CW'(DEPTH))
      stb_nx = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      stb       <= 1'b0;
      adr_off   <= '0;
      wcnt      <= '0;
      line_base <= '0;
      next_base <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      phase     <= 1'b0;
      last_byte <= '0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nx;
      stb       <= stb_nx;
      adr_off   <= adr_nx;
      wcnt      <= wcnt_nx;
      last_byte <= pix_data_w;
      count     <= count_nx;
      if (line_start) begin
        line_base <= base_sel;
        next_base <= base_sel + LINE_BYTES;
      end else if (frame_start) begin
        next_base <= base_fs;
      end
      if (bus.pix_rd && !pix_valid_w)
        underrun <= 1'b1;
      if (line_start) begin
        wptr  <= '0;
        rptr  <= '0;
        phase <= 1'b0;
      end else begin
        if (push)
          wptr <= wptr + 1'b1;
        if (pop_byte) begin
          phase <= ~phase;
          if (phase)
            rptr <= rptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst)
      mem[wptr] <= bus.fml_di;
  end

  assign pix_data_w = pix_valid_w ? (phase ? mem[rptr][15:8] : mem[rptr][7:0]) : last_byte;

  assign bus.fml_adr   = FB_BASE + {{(fml_depth - 16){1'b0}}, adr_off};
  assign bus.fml_stb   = stb;
  assign bus.pix_data  = pix_data_w;
  assign bus.pix_valid = pix_valid_w;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Randomised bench for vga_line_prefetch.
// A transaction-level model (byte queue, base arithmetic) is compared with the DUT every cycle.
module tb_vga_line_prefetch;
  localparam logic [24:0] FB  = 25'h0A0000;
  localparam int          WPL = 160;

  logic        clk = 1'b1;
  logic        rst = 1'b1;
  logic [15:0] start_addr = '0;
  logic        frame_start = 1'b0, line_start = 1'b0, line_repeat = 1'b0;
  logic        busy, underrun;

  vga_line_prefetch_if #(.fml_depth(25)) bus ();

  vga_line_prefetch #(
    .fml_depth(25), .FB_BASE(25'h0A0000), .WORDS_PER_LINE(160), .FIFO_AW(5)
  ) dut (
    .clk(clk), .rst(rst), .start_addr(start_addr), .frame_start(frame_start),
    .line_start(line_start), .line_repeat(line_repeat), .bus(bus),
    .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_FETCH, M_DRAIN} mmode_t;
  mmode_t      m_mode = M_IDLE;
  bit          m_stb = 0, m_under = 0, chk_en = 0;
  int          m_fbase = 0, m_k = 0, m_line = 0, m_next = 0;
  logic [24:0] m_dadr = '0;
  logic [7:0]  m_hold = '0;
  logic [7:0]  q[$];
  logic [24:0] acked[$];

  function automatic logic [24:0] fetch_adr();
    return FB + 25'((m_fbase + 2 * m_k) & 32'hFFFF);
  endfunction

  always @(posedge clk) begin
    int  bnow, bsel;
    bit  acc, pend;
    if (rst) begin
      m_mode = M_IDLE; m_stb = 0; m_under = 0; m_fbase = 0; m_k = 0;
      m_line = 0; m_next = 0; m_hold = '0; q.delete(); chk_en = 1;
    end else begin
      acc  = m_stb && bus.fml_ack;
      pend = m_stb && !bus.fml_ack;
      if (acc) acked.push_back(bus.fml_adr);
      if (bus.pix_rd) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_under = 1;
      end
      bnow = frame_start ? ((int'(start_addr) * 2) & 32'hFFFF) : m_next;
      bsel = line_repeat ? m_line : bnow;
      case (m_mode)
        M_IDLE:
          if (line_start) begin m_mode = M_FETCH; m_fbase = bsel; m_k = 0; end
        M_FETCH:
          if (line_start && pend) begin
            m_mode = M_DRAIN; m_dadr = fetch_adr();
          end else if (line_start) begin
            m_fbase = bsel; m_k = 0;
          end else if (acc) begin
            q.push_back(bus.fml_di[7:0]);
            q.push_back(bus.fml_di[15:8]);
            m_k++;
            if (m_k == WPL) m_mode = M_IDLE;
          end
        M_DRAIN:
          if (acc) begin m_mode = M_FETCH; m_fbase = line_start ? bsel : m_line; m_k = 0; end
        default: m_mode = M_IDLE;
      endcase
      if (line_start) begin
        q.delete();
        m_line = bsel;
        m_next = (bsel + 2 * WPL) & 32'hFFFF;
      end else if (frame_start) begin
        m_next = (int'(start_addr) * 2) & 32'hFFFF;
      end
      m_stb = pend || (m_mode == M_FETCH && (q.size() + 1) / 2 < 32);
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (chk_en) begin
      exp_d  = (q.size() > 0) ? q[0] : m_hold;
      m_hold = exp_d;
      chk("stb", 32'(bus.fml_stb), 32'(m_stb));
      if (m_stb)
        chk("adr", 32'(bus.fml_adr), 32'((m_mode == M_DRAIN) ? m_dadr : fetch_adr()));
      chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
      chk("pix_valid", 32'(bus.pix_valid), 32'(q.size() > 0));
      chk("pix_data", 32'(bus.pix_data), 32'(exp_d));
      chk("underrun", 32'(underrun), 32'(m_under));
    end
  end

  // ---------------- FML slave and pixel consumer ----------------
  int wait_cfg = 0, wcur = 0;
  always @(negedge clk) begin
    if (bus.fml_stb === 1'b1 && !rst) begin
      if (wcur >= wait_cfg) begin
        bus.fml_ack = 1'b1; bus.fml_di = 16'($urandom); wcur = 0;
      end else begin
        bus.fml_ack = 1'b0; wcur++;
      end
    end else begin
      bus.fml_ack = 1'b0; bus.fml_di = '0; wcur = 0;
    end
  end

  int rd_prob = 100, pops_req = 0;
  bit force_rd = 0;
  always @(negedge clk) begin
    if (force_rd) begin
      bus.pix_rd = 1'b1; force_rd = 0;
    end else if (pops_req > 0) begin
      bus.pix_rd = (bus.pix_valid === 1'b1);
      if (bus.pix_valid === 1'b1) pops_req--;
    end else begin
      bus.pix_rd = (bus.pix_valid === 1'b1) && ($urandom_range(99) < rd_prob);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse(input bit fs, input bit ls, input bit rep, input logic [15:0] sa);
    @(negedge clk);
    frame_start = fs; line_start = ls; line_repeat = rep; start_addr = sa;
    @(negedge clk);
    frame_start = 0; line_start = 0; line_repeat = 1'($urandom);
  endtask

  task automatic wait_idle(input string name, input int bound);
    for (int i = 0; i < bound && busy !== 1'b0; i++) @(negedge clk);
    chk(name, 32'(busy), 32'd0);
  endtask

  task automatic wait_empty(input string name, input int bound);
    for (int i = 0; i < bound && bus.pix_valid !== 1'b0; i++) @(negedge clk);
    chk(name, 32'(bus.pix_valid), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    wait_cycles(3);
    chk("rst_adr", 32'(bus.fml_adr), 32'(FB));
    chk("rst_stb", 32'(bus.fml_stb), 32'd0);
    chk("rst_data", 32'(bus.pix_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 0;

    // Line from start_addr 0x0010, zero-wait acks
    acked.delete();
    pulse(1, 0, 0, 16'h0010);
    pulse(0, 1, 0, 16'h0000);
    wait_idle("t1_done", 2000);
    chk("t1_count", 32'(acked.size()), 32'd160);
    chk("t1_first", 32'(acked[0]), 32'h0A0020);
    chk("t1_last", 32'(acked[159]), 32'h0A015E);
    wait_empty("t1_empty", 1000);

    // Line repeat, then advance
    acked.delete();
    pulse(0, 1, 1, 16'h0000);
    wait_idle("t2a_done", 2000);
    chk("t2_repeat", 32'(acked[0]), 32'h0A0020);
    wait_empty("t2a_empty", 1000);
    acked.delete();
    pulse(0, 1, 0, 16'h0000);
    wait_idle("t2b_done", 2000);
    chk("t2_next", 32'(acked[0]), 32'h0A0160);
    wait_empty("t2b_empty", 1000);

    // FIFO-full stall and one-slot release
    rd_prob = 0; wait_cfg = 2;
    acked.delete();
    pulse(0, 1, 0, 16'h0000);
    wait_cycles(300);
    chk("t3_stall_acks", 32'(acked.size()), 32'd32);
    chk("t3_stall_stb", 32'(bus.fml_stb), 32'd0);
    pops_req = 2;
    wait_cycles(40);
    chk("t3_one_more", 32'(acked.size()), 32'd33);
    rd_prob = 100;
    wait_idle("t3_done", 3000);
    wait_empty("t3_empty", 1000);

    // Offset wrap inside the 64 KiB window
    wait_cfg = 0;
    pulse(1, 0, 0, 16'hFFF0);
    acked.delete();
    pulse(0, 1, 0, 16'h0000);
    wait_idle("t4_done", 2000);
    chk("t4_pre_wrap", 32'(acked[15]), 32'h0AFFFE);
    chk("t4_wrap", 32'(acked[16]), 32'h0A0000);
    chk("t4_last", 32'(acked[159]), 32'h0A011E);
    wait_empty("t4_empty", 1000);

    // line_start with a request pending -> stale word dropped, new base used
    wait_cfg = 5;
    acked.delete();
    pulse(0, 1, 0, 16'h0000);
    @(negedge clk);
    pulse(0, 1, 0, 16'h0000);
    wait_idle("t5_done", 3000);
    chk("t5_stale", 32'(acked[0]), 32'h0A0120);
    chk("t5_new", 32'(acked[1]), 32'h0A0260);
    chk("t5_count", 32'(acked.size()), 32'd161);
    wait_empty("t5_empty", 1000);

    // Randomised traffic: interrupted lines, frame/line coincidence, varying latency and drain rate
    for (int it = 0; it < 40; it++) begin
      int kind;
      rd_prob  = 20 + int'($urandom_range(80));
      wait_cfg = int'($urandom_range(3));
      kind     = int'($urandom_range(3));
      if (kind == 0) pulse(1, 1, 1'($urandom), 16'($urandom));
      else if (kind == 1) begin
        pulse(1, 0, 0, 16'($urandom));
        pulse(0, 1, 1'($urandom), 16'h0000);
      end else pulse(0, 1, 1'($urandom), 16'h0000);
      wait_cycles(20 + int'($urandom_range(600)));
    end
    rd_prob = 100; wait_cfg = 0;
    wait_idle("rand_done", 5000);
    wait_empty("rand_empty", 1000);

    // Underrun is sticky; reset mid-fetch returns everything to reset values
    force_rd = 1;
    wait_cycles(3);
    chk("t6_underrun", 32'(underrun), 32'd1);
    wait_cycles(10);
    chk("t6_sticky", 32'(underrun), 32'd1);
    pulse(0, 1, 0, 16'h0000);
    wait_cycles(20);
    rst = 1;
    @(negedge clk);
    chk("t6_rst_stb", 32'(bus.fml_stb), 32'd0);
    chk("t6_rst_adr", 32'(bus.fml_adr), 32'(FB));
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(bus.pix_valid), 32'd0);
    chk("t6_rst_data", 32'(bus.pix_data), 32'd0);
    chk("t6_rst_underrun", 32'(underrun), 32'd0);
    rst = 0;
    wait_cycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
